// File: rtl/instr_ram_loader.sv
// Runtime-loadable instruction RAM: streams a program image in over valid/ready, holds the CPU until loaded.
// Optional LOAD_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH sum of the accepted words.
module instr_ram_loader #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DEPTH       = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'h6C000000,
    parameter logic [5:0]            HLT_OPCODE  = 6'b011100,
    parameter bit                    STOP_ON_HLT = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  cpu_hold,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [1:0]            fsm_state
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] load_checksum
`endif
);

    // Handshake: a beat transfers on a rising edge where load_valid && load_ready;
    // load_ready is high exactly while the FSM is in LOAD.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic hlt_hit;
    logic at_end;
    logic terminate;
    logic overflow;
    logic start_load;

    assign accept     = load_valid && (state == LOAD);
    assign hlt_hit    = STOP_ON_HLT && (load_data[DATA_WIDTH-1 -: 6] == HLT_OPCODE);
    assign at_end     = (load_count == (ADDR_WIDTH+1)'(DEPTH-1));
    assign terminate  = accept && (load_last || hlt_hit || at_end);
    assign overflow   = terminate && at_end && !load_last && !hlt_hit;
    // load_start during LOAD is deliberately ignored so an image cannot be torn mid-stream.
    assign start_load = load_start && (state != LOAD);
    assign fsm_state  = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE: begin
                if (load_start) next_state = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (terminate) next_state = RUN;
            end
            RUN: begin
                cpu_hold = 1'b0;
                if (load_start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_count <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_done <= terminate;
            if (start_load) begin
                load_count <= '0;
                load_error <= 1'b0;
            end else if (accept) begin
                load_count <= load_count + 1'b1;
                if (overflow) load_error <= 1'b1;
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_checksum <= '0;
        end else if (start_load) begin
            load_checksum <= '0;
        end else if (accept) begin
            load_checksum <= load_checksum + load_data;
        end
    end
`endif

    // The array is never cleared; stale contents are hidden by the load_count mask below.
    always_ff @(posedge clock) begin
        if (accept) mem[load_count[ADDR_WIDTH-1:0]] <= load_data;
    end

    always_comb begin
        instr_out = NOP_WORD;
        if ((state == RUN) && ({1'b0, fetch_address} < load_count))
            instr_out = mem[fetch_address];
    end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed bench for instr_ram_loader: a default-size instance and a DEPTH=4 instance share one stimulus stream.
module tb_instr_ram_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam logic [DW-1:0] NOP = 32'h6C000000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic [AW-1:0] fetch_address = '0;

    logic          load_ready, load_done, load_error, cpu_hold;
    logic [AW:0]   load_count;
    logic [DW-1:0] instr_out;
    logic [1:0]    fsm_state;

    logic          s_load_ready, s_load_done, s_load_error, s_cpu_hold;
    logic [AW:0]   s_load_count;
    logic [DW-1:0] s_instr_out;
    logic [1:0]    s_fsm_state;

`ifdef LOAD_CHECKSUM_EN
    logic [DW-1:0] load_checksum, s_load_checksum;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instr_ram_loader dut (
        .clock(clock), .reset_n(reset_n), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_count(load_count), .load_done(load_done),
        .load_error(load_error), .cpu_hold(cpu_hold),
        .fetch_address(fetch_address), .instr_out(instr_out),
        .fsm_state(fsm_state)
`ifdef LOAD_CHECKSUM_EN
        , .load_checksum(load_checksum)
`endif
    );

    instr_ram_loader #(.DEPTH(4)) dut_small (
        .clock(clock), .reset_n(reset_n), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(s_load_ready), .load_count(s_load_count), .load_done(s_load_done),
        .load_error(s_load_error), .cpu_hold(s_cpu_hold),
        .fetch_address(fetch_address), .instr_out(s_instr_out),
        .fsm_state(s_fsm_state)
`ifdef LOAD_CHECKSUM_EN
        , .load_checksum(s_load_checksum)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } fetch_vec_t;

    fetch_vec_t tbl[6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch_check(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        fetch_address = addr;
        #1;
        check(name, instr_out, exp);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        fetch_check("rst_fetch0", 10'd0, NOP);
        reset_n = 1'b1;
        step();
        check("idle_hold", 32'(cpu_hold), 32'd1);

        // Basic three-beat load
        start_load();
        check("load_ready", 32'(load_ready), 32'd1);
        check("load_hold", 32'(cpu_hold), 32'd1);
        beat(32'h0000000A, 1'b0);
        beat(32'h0000000B, 1'b0);
        check("mid_done", 32'(load_done), 32'd0);
        beat(32'h0000000C, 1'b1);
        check("b3_done", 32'(load_done), 32'd1);
        check("b3_count", 32'(load_count), 32'd3);
        check("b3_hold", 32'(cpu_hold), 32'd0);
        check("b3_ready", 32'(load_ready), 32'd0);
        step();
        check("done_pulse_end", 32'(load_done), 32'd0);

        tbl[0] = '{10'd0,    32'h0000000A};
        tbl[1] = '{10'd1,    32'h0000000B};
        tbl[2] = '{10'd2,    32'h0000000C};
        tbl[3] = '{10'd3,    NOP};
        tbl[4] = '{10'd1023, NOP};
        tbl[5] = '{10'd4,    NOP};
        for (int i = 0; i < 6; i++) begin
            fetch_address = tbl[i].addr;
            #1;
            check($sformatf("tbl_fetch%0d", i), instr_out, tbl[i].exp);
        end

        // Hlt terminates the load; the following word must not land
        start_load();
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_count", 32'(load_count), 32'd0);
        fetch_check("reload_fetch0", 10'd0, NOP);
        beat(32'h00000001, 1'b0);
        beat(32'h70000000, 1'b0);
        check("hlt_done", 32'(load_done), 32'd1);
        check("hlt_count", 32'(load_count), 32'd2);
        check("hlt_ready", 32'(load_ready), 32'd0);
        beat(32'h00000005, 1'b0);
        check("hlt_count_after", 32'(load_count), 32'd2);
        fetch_check("hlt_fetch0", 10'd0, 32'h00000001);
        fetch_check("hlt_fetch1", 10'd1, 32'h70000000);
        fetch_check("hlt_fetch2", 10'd2, NOP);

        // Overflow: 5 beats without last; DEPTH=4 instance stops at 4
        start_load();
        beat(32'h00000011, 1'b0);
        beat(32'h00000012, 1'b0);
        beat(32'h00000013, 1'b0);
        check("ovf_s_err_before", 32'(s_load_error), 32'd0);
        beat(32'h00000014, 1'b0);
        check("ovf_s_done", 32'(s_load_done), 32'd1);
        check("ovf_s_err", 32'(s_load_error), 32'd1);
        check("ovf_s_hold", 32'(s_cpu_hold), 32'd0);
        check("ovf_s_ready", 32'(s_load_ready), 32'd0);
        check("ovf_big_hold", 32'(cpu_hold), 32'd1);
        beat(32'h00000015, 1'b0);
        check("ovf_s_count", 32'(s_load_count), 32'd4);
        check("ovf_s_err_sticky", 32'(s_load_error), 32'd1);
        check("ovf_big_count", 32'(load_count), 32'd5);
        check("ovf_big_err", 32'(load_error), 32'd0);
        fetch_address = 10'd3;
        #1;
        check("ovf_s_fetch3", s_instr_out, 32'h00000014);
        fetch_address = 10'd4;
        #1;
        check("ovf_s_fetch4", s_instr_out, NOP);
        beat(32'h00000016, 1'b1);
        check("ovf_big_done", 32'(load_done), 32'd1);
        check("ovf_big_count6", 32'(load_count), 32'd6);
        fetch_check("ovf_big_fetch5", 10'd5, 32'h00000016);

        // Reset in the middle of a load, then reload
        start_load();
        check("s_err_cleared", 32'(s_load_error), 32'd0);
        beat(32'h00000021, 1'b0);
        beat(32'h00000022, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mrst_count", 32'(load_count), 32'd0);
        check("mrst_hold", 32'(cpu_hold), 32'd1);
        check("mrst_ready", 32'(load_ready), 32'd0);
        fetch_check("mrst_fetch0", 10'd0, NOP);
        #1;
        reset_n = 1'b1;
        step();
        start_load();
        beat(32'h00000031, 1'b0);
        beat(32'h00000032, 1'b1);
        check("rl_count", 32'(load_count), 32'd2);
        fetch_check("rl_fetch0", 10'd0, 32'h00000031);
        fetch_check("rl_fetch1", 10'd1, 32'h00000032);
        fetch_check("rl_fetch2", 10'd2, NOP);

`ifdef LOAD_CHECKSUM_EN
        start_load();
        check("cs_cleared0", load_checksum, 32'd0);
        beat(32'hFFFFFFFF, 1'b0);
        beat(32'h00000002, 1'b1);
        check("cs_done", 32'(load_done), 32'd1);
        check("cs_sum", load_checksum, 32'h00000001);
        start_load();
        check("cs_cleared", load_checksum, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
